// File: rtl/periphery_pkg.sv
// Shared widths, opcode and state encodings, and status-word bit positions
// for the DPU host IO controller.
package periphery_pkg;

  localparam int INPUT_DATA_L = 32;
  localparam int IO_OPCODE_L  = 4;
  localparam int ADDR_L       = 16;
  localparam int OUT_L        = 32;
  localparam int RD_TIMEOUT   = 15;
  localparam int CNT_L        = 32;

  typedef enum logic [IO_OPCODE_L-1:0] {
    OP_NOP       = 4'd0,
    OP_SET_ADDR  = 4'd1,
    OP_WR_INSTR  = 4'd2,
    OP_WR_DATA   = 4'd3,
    OP_RD_DATA   = 4'd4,
    OP_RD_CYCLES = 4'd5,
    OP_RD_STATUS = 4'd6
  } io_opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_DONE    = 3'd2,
    ST_RD_WAIT = 3'd3
  } io_state_t;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_CORE_DONE = 3;
  localparam int STAT_RD_ERR    = 4;

endpackage

// File: rtl/dpu_io_exec_seq.sv
// Core execution sequencer: reset/enable handshake with the host, pause and
// resume, completion detection and a saturating execution-cycle counter.
module dpu_io_exec_seq
  import periphery_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             reset_exec_i,
  input  logic             enable_exec_i,
  input  logic             core_done_i,
  output io_state_t        state_o,
  output logic             core_rst_o,
  output logic             core_en_o,
  output logic             done_o,
  output logic [CNT_L-1:0] cycles_o
);

  io_state_t        state_q;
  logic             core_rst_q;
  logic             core_en_q;
  logic             done_q;
  logic [CNT_L-1:0] cycles_q;

  // While a data read is outstanding the host controls are simply not
  // sampled; they are levels, so they take effect once the read resolves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      done_q     <= 1'b0;
      cycles_q   <= '0;
    end else if (!hold_i) begin
      if (reset_exec_i) begin
        state_q    <= ST_IDLE;
        core_rst_q <= 1'b1;
        core_en_q  <= 1'b0;
        done_q     <= 1'b0;
        cycles_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (enable_exec_i) begin
              core_rst_q <= 1'b0;
              core_en_q  <= 1'b1;
              state_q    <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            if (core_done_i) begin
              core_en_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_DONE;
            end else if (enable_exec_i) begin
              core_en_q <= 1'b1;
              if (cycles_q != '1) cycles_q <= cycles_q + CNT_L'(1);
            end else begin
              core_en_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state_o    = state_q;
  assign core_rst_o = core_rst_q;
  assign core_en_o  = core_en_q;
  assign done_o     = done_q;
  assign cycles_o   = cycles_q;

endmodule

// File: rtl/dpu_io_ctrl.sv
// Device side of the DPU host IO port: decodes host opcodes into memory
// writes/reads and status reads, and delegates core sequencing to exec_seq.
module dpu_io_ctrl
  import periphery_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_DATA_L-1:0] in,
  input  logic [IO_OPCODE_L-1:0]  io_opcode,
  input  logic                    reset_execution_io,
  input  logic                    enable_execution_io,
  output logic                    done_execution_io,
  output logic [OUT_L-1:0]        out,
  output logic [ADDR_L-1:0]       mem_addr,
  output logic [INPUT_DATA_L-1:0] mem_wr_data,
  output logic                    instr_wr_en,
  output logic                    data_wr_en,
  output logic                    data_rd_en,
  input  logic [OUT_L-1:0]        data_rd_data,
  input  logic                    data_rd_valid,
  output logic                    core_rst,
  output logic                    core_en,
  input  logic                    core_done
);

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  io_opcode_t              op_w;
  io_state_t               exec_state;
  logic [CNT_L-1:0]        cycles;
  logic                    decode_en;
  logic                    hold;
  logic [OUT_L-1:0]        status_w;

  logic [ADDR_L-1:0]       mem_addr_q, mem_addr_d;
  logic [INPUT_DATA_L-1:0] wr_data_q, wr_data_d;
  logic                    instr_wr_q, instr_wr_d;
  logic                    data_wr_q, data_wr_d;
  logic                    rd_en_q, rd_en_d;
  logic [OUT_L-1:0]        out_q, out_d;
  logic                    rd_wait_q, rd_wait_d;
  logic                    rd_err_q, rd_err_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;

  assign op_w      = io_opcode_t'(io_opcode);
  assign decode_en = !rd_wait_q && (exec_state == ST_IDLE || exec_state == ST_DONE);
  assign hold      = rd_wait_q || (decode_en && op_w == OP_RD_DATA);

  dpu_io_exec_seq u_exec_seq (
    .clk_i         (clk),
    .rst_i         (rst),
    .hold_i        (hold),
    .reset_exec_i  (reset_execution_io),
    .enable_exec_i (enable_execution_io),
    .core_done_i   (core_done),
    .state_o       (exec_state),
    .core_rst_o    (core_rst),
    .core_en_o     (core_en),
    .done_o        (done_execution_io),
    .cycles_o      (cycles)
  );

  always_comb begin
    status_w                            = '0;
    status_w[STAT_STATE_LSB +: 3]       = exec_state;
    status_w[STAT_CORE_DONE]            = core_done;
    status_w[STAT_RD_ERR]               = rd_err_q;
  end

  // The address advances on the cycle after a write strobe, so the strobe
  // cycle itself always presents the address the write was issued against.
  always_comb begin
    mem_addr_d = mem_addr_q;
    wr_data_d  = wr_data_q;
    instr_wr_d = 1'b0;
    data_wr_d  = 1'b0;
    rd_en_d    = 1'b0;
    out_d      = out_q;
    rd_wait_d  = rd_wait_q;
    rd_err_d   = rd_err_q;
    tmo_d      = tmo_q;
    if (instr_wr_q || data_wr_q) mem_addr_d = mem_addr_q + ADDR_L'(1);
    if (rd_wait_q) begin
      if (data_rd_valid) begin
        out_d      = data_rd_data;
        mem_addr_d = mem_addr_q + ADDR_L'(1);
        rd_wait_d  = 1'b0;
      end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
        out_d     = '1;
        rd_err_d  = 1'b1;
        rd_wait_d = 1'b0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else if (decode_en) begin
      case (op_w)
        OP_SET_ADDR:  mem_addr_d = in[ADDR_L-1:0];
        OP_WR_INSTR: begin
          instr_wr_d = 1'b1;
          wr_data_d  = in;
        end
        OP_WR_DATA: begin
          data_wr_d = 1'b1;
          wr_data_d = in;
        end
        OP_RD_DATA: begin
          rd_en_d   = 1'b1;
          rd_wait_d = 1'b1;
          tmo_d     = '0;
        end
        OP_RD_CYCLES: out_d = OUT_L'(cycles);
        OP_RD_STATUS: begin
          out_d    = status_w;
          rd_err_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q <= '0;
      wr_data_q  <= '0;
      instr_wr_q <= 1'b0;
      data_wr_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      out_q      <= '0;
      rd_wait_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      wr_data_q  <= wr_data_d;
      instr_wr_q <= instr_wr_d;
      data_wr_q  <= data_wr_d;
      rd_en_q    <= rd_en_d;
      out_q      <= out_d;
      rd_wait_q  <= rd_wait_d;
      rd_err_q   <= rd_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = wr_data_q;
  assign instr_wr_en = instr_wr_q;
  assign data_wr_en  = data_wr_q;
  assign data_rd_en  = rd_en_q;
  assign out         = out_q;

endmodule

// File: doc/dpu_io_ctrl.md
Name: dpu_io_ctrl

Overview:
- Device-side end of the DPU host IO port: the module that receives what the synchronous testbench/host drives (in, io_opcode, reset_execution_io, enable_execution_io) and produces done_execution_io and out.
- Decodes host opcodes into instruction- and data-memory writes and data-memory reads.
- Sequences core reset/enable, counts execution cycles and returns read data or status on out.
- Sits at the DPU top between the pads/IO wrapper and the memories and core.

Parameters:
INPUT_DATA_L, 32, width of host input word in
IO_OPCODE_L, 4, width of io_opcode
ADDR_L, 16, memory address width
OUT_L, 32, width of out
RD_TIMEOUT, 15, cycles to wait for data_rd_valid before flagging a read error

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in  input  INPUT_DATA_L  host data/address word
io_opcode  input  IO_OPCODE_L  host command, sampled every posedge
reset_execution_io  input  1  host request to reset the core
enable_execution_io  input  1  host request to start/continue execution
done_execution_io  output  1  execution finished, registered
out  output  OUT_L  read data / status, registered
mem_addr  output  ADDR_L  shared memory address pointer
mem_wr_data  output  INPUT_DATA_L  write data
instr_wr_en  output  1  one-cycle instruction-memory write strobe
data_wr_en  output  1  one-cycle data-memory write strobe
data_rd_en  output  1  one-cycle data-memory read request
data_rd_data  input  OUT_L  read return
data_rd_valid  input  1  read return valid, any latency from 1 cycle after data_rd_en
core_rst  output  1  core reset, registered
core_en  output  1  core enable, registered
core_done  input  1  core completion, level

Behaviour:
- Reset: one rst cycle is synchronous and active-high. After it, all outputs are 0, core_rst=1 and state=IDLE.
- Reset mid-operation: rst in any state aborts immediately. Any pending read response is dropped.
- Opcodes, decoded only in IDLE: NOP=0, SET_ADDR=1, WR_INSTR=2, WR_DATA=3, RD_DATA=4, RD_CYCLES=5, RD_STATUS=6. Other values behave as NOP.
- SET_ADDR: mem_addr <= in[ADDR_L-1:0] next cycle.
- WR_INSTR / WR_DATA: next cycle, the matching wr_en=1 for exactly one cycle with mem_wr_data=in and the current mem_addr. mem_addr then increments, wrapping from 2^ADDR_L-1 to 0.
  - Back-to-back write opcodes give one write per cycle.
- RD_DATA: data_rd_en=1 for one cycle, then state goes to RD_WAIT.
  - On data_rd_valid: out <= data_rd_data, mem_addr increments, back to IDLE.
  - After RD_TIMEOUT cycles with no valid: out <= all ones, the sticky rd_err status bit is set, back to IDLE.
  - data_rd_valid outside RD_WAIT is ignored.
- RD_CYCLES: out <= cycle counter, one-cycle latency.
- RD_STATUS: out <= {zeros, rd_err, core_done, state[2:0]}. This read clears rd_err.
- Execution control is evaluated in every state except RD_WAIT, where it is deferred until exit.
  - reset_execution_io has priority over enable_execution_io.
  - reset_execution_io=1: core_rst=1, core_en=0, cycle counter=0, done_execution_io=0, state goes to IDLE.
  - enable_execution_io=1 in IDLE with reset low: core_rst=0, core_en=1, state goes to EXEC.
- EXEC:
  - Cycle counter increments each cycle and saturates at 2^32-1.
  - Opcodes are ignored.
  - Deasserting enable_execution_io pauses: core_en=0 and the counter holds, state stays EXEC.
  - Reasserting enable resumes.
  - core_done=1: core_en=0, done_execution_io=1, state goes to DONE.
- DONE:
  - done_execution_io stays 1 and opcodes are decoded as in IDLE, so results can be read back.
  - A new enable with reset low is ignored until reset_execution_io is asserted.
- Output timing: all outputs are registered. Opcode-to-output latency is 1 cycle.

Decomposition:
- periphery_pkg holds INPUT_DATA_L, IO_OPCODE_L, the opcode enum io_opcode_t, the state enum io_state_t and the status bit positions.
- One sub-module, dpu_io_exec_seq: the execution FSM plus the cycle counter.
- The opcode decoder and read path stay in the top.

Test Plan:
- SET_ADDR in=0x0010, then 3×WR_DATA in=0xA,0xB,0xC -> data_wr_en pulses at addr 0x10,0x11,0x12 with those data; mem_addr ends at 0x13.
- SET_ADDR 0xFFFF, WR_INSTR 0x5 twice -> writes at 0xFFFF then 0x0000 (wrap).
- SET_ADDR 0x20, RD_DATA with memory model valid after 3 cycles returning 0x1234 -> out=0x1234, mem_addr=0x21; repeat with no valid -> after 15 cycles out=0xFFFFFFFF; RD_STATUS shows rd_err=1, and a second RD_STATUS shows rd_err=0.
- reset_execution_io pulse, enable 100 cycles, core_done raised at cycle 100 -> done_execution_io=1, RD_CYCLES returns 100, core_en=0.
- Enable for 40 cycles, drop enable for 10, re-enable and finish after 20 more -> RD_CYCLES=60.
- reset_execution_io and enable_execution_io high in the same cycle -> core_rst=1, core_en=0. Also assert rst during RD_WAIT -> all outputs 0 next cycle, and a late data_rd_valid is ignored.
